// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types and default sizing for the FIFO read-side streamer.
//   state_t        : controller states (IDLE, RUN, DRAIN)
//   DEF_DSIZE      : default data width
//   DEF_BURST_LEN  : default beats per m_last burst (legal 1..256)
//   DEF_CNT_W      : default popped-word counter width
package fifo_rd_pkg;

    localparam int unsigned DEF_DSIZE     = 8;
    localparam int unsigned DEF_BURST_LEN = 4;
    localparam int unsigned DEF_CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry in-order output buffer.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write push_data this cycle (caller guarantees occ < 2)
//   push_data : word to store
//   pop       : remove the oldest word this cycle (caller guarantees occ > 0)
//   head      : oldest stored word
//   occ       : number of stored words, 0..2
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DSIZE = DEF_DSIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DSIZE-1:0] push_data,
    input  logic             pop,
    output logic [DSIZE-1:0] head,
    output logic [1:0]       occ
);

    // slot0 always holds the oldest word; slot1 the younger one when occ==2
    logic [DSIZE-1:0] slot0;
    logic [DSIZE-1:0] slot1;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ   <= '0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) slot0 <= push_data;
                    else             slot1 <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; shift and append to keep order
                    if (occ == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end else begin
                        slot0 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = slot0;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops a first-word-fall-through FIFO and presents the words
// as a valid/ready stream with m_last framing every BURST_LEN beats.
//   rclk, rrst      : clock, synchronous active-high reset
//   rdata, rempty   : FIFO head word and empty flag
//   rinc            : FIFO pop strobe
//   enable          : permits popping
//   m_data, m_valid : stream data / valid
//   m_ready         : downstream accept
//   m_last          : final beat of each burst
//   word_cnt        : words popped since reset (wraps)
//   busy            : controller not in IDLE
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DSIZE     = DEF_DSIZE,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    input  logic             enable,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [CNT_W-1:0] word_cnt,
    output logic             busy
);

    localparam int unsigned     BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0]   LAST_BEAT = BW'(BURST_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       occ;
    logic [1:0]       occ_nxt;
    logic [DSIZE-1:0] head;
    logic             xfer;
    logic [BW-1:0]    beat_cnt;

    fifo_rd_skid #(
        .DSIZE(DSIZE)
    ) u_skid (
        .clk       (rclk),
        .rst       (rrst),
        .push      (rinc),
        .push_data (rdata),
        .pop       (xfer),
        .head      (head),
        .occ       (occ)
    );

    assign xfer    = m_valid & m_ready;
    assign occ_nxt = occ + {1'b0, rinc} - {1'b0, xfer};

    always_ff @(posedge rclk) begin
        if (rrst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (enable) state_nxt = RUN;
            RUN:   if (!enable) state_nxt = (occ_nxt != 2'd0) ? DRAIN : IDLE;
            DRAIN: begin
                if (enable)                 state_nxt = RUN;
                else if (occ_nxt == 2'd0)   state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced low while rrst is held so a reset mid-burst is
    // invisible downstream from the cycle it is asserted. Popping is gated to
    // RUN so the first cycle after reset (IDLE) never pops.
    always_comb begin
        rinc    = 1'b0;
        m_valid = 1'b0;
        busy    = 1'b0;
        if (!rrst) begin
            rinc    = (state == RUN) & enable & ~rempty & (occ < 2'd2);
            m_valid = (occ != 2'd0);
            busy    = (state != IDLE);
        end
    end

    assign m_data = m_valid ? head : '0;
    assign m_last = m_valid & (beat_cnt == LAST_BEAT);

    always_ff @(posedge rclk) begin
        if (rrst) begin
            beat_cnt <= '0;
            word_cnt <= '0;
        end else begin
            if (xfer) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BW'(1);
            if (rinc) word_cnt <= word_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed bench for fifo_rd_stream. A small FWFT FIFO
// model feeds the main instance; a second instance (CNT_W=4, BURST_LEN=1)
// covers counter wrap and single-beat framing.
module tb_fifo_rd_stream;
    import fifo_rd_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] rdata;
    logic       rempty;
    logic       rinc;
    logic       enable;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic [15:0] word_cnt;
    logic       busy;

    logic [7:0] rdata2;
    logic       rempty2;
    logic       rinc2;
    logic       en2;
    logic [7:0] m_data2;
    logic       m_valid2;
    logic       m_ready2;
    logic       m_last2;
    logic [3:0] word_cnt2;
    logic       busy2;

    int checks = 0;
    int errors = 0;

    // FIFO model: written by the stimulus, popped on rinc
    logic [7:0]  mem [64];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    logic        hold_empty;

    // transfer monitor
    logic [7:0] out_data [64];
    logic       out_last [64];
    int         out_n     = 0;
    int         underflow = 0;
    int         rinc2_n   = 0;

    assign rempty = (rd_ptr == wr_ptr) || hold_empty;
    assign rdata  = mem[rd_ptr % 64];

    fifo_rd_stream #(
        .DSIZE(8), .BURST_LEN(4), .CNT_W(16)
    ) u_dut (
        .rclk(clk), .rrst(rst), .rdata(rdata), .rempty(rempty), .rinc(rinc),
        .enable(enable), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .word_cnt(word_cnt), .busy(busy)
    );

    fifo_rd_stream #(
        .DSIZE(8), .BURST_LEN(1), .CNT_W(4)
    ) u_w (
        .rclk(clk), .rrst(rst), .rdata(rdata2), .rempty(rempty2), .rinc(rinc2),
        .enable(en2), .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready2),
        .m_last(m_last2), .word_cnt(word_cnt2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_valid && m_ready) begin
            out_data[out_n % 64] <= m_data;
            out_last[out_n % 64] <= m_last;
            out_n <= out_n + 1;
        end
        if (rinc) rd_ptr <= rd_ptr + 1;
        underflow <= underflow + ((rinc && rempty) ? 1 : 0) + ((rinc2 && rempty2) ? 1 : 0);
        if (rinc2) rinc2_n <= rinc2_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 64] = d;
        wr_ptr++;
    endtask

    task automatic chk_out(input int lo, input int hi, input logic [7:0] ed [31], input logic el [31]);
        for (int i = lo; i < hi; i++) begin
            chk($sformatf("out_data[%0d]", i), 32'(out_data[i]), 32'(ed[i]));
            chk($sformatf("out_last[%0d]", i), 32'(out_last[i]), 32'(el[i]));
        end
    endtask

    initial begin
        logic [7:0] ed [31];
        logic       el [31];
        logic       s1_rinc [6];
        logic       s1_vld  [6];
        logic [7:0] s1_data [6];
        logic       s1_last [6];

        ed = '{8'h11, 8'h22, 8'h33, 8'h44,
               8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5,
               8'hB0, 8'hB1,
               8'hB2, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8,
               8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD6, 8'hD7, 8'hD8, 8'hD9};
        el = '{0, 0, 0, 1,
               0, 0, 0, 1, 0, 0,
               0, 1,
               0, 0, 0, 1, 0, 0, 0, 1, 0, 0,
               0, 1, 0, 0, 0, 0, 0, 0, 1};
        s1_rinc = '{1, 1, 1, 1, 0, 0};
        s1_vld  = '{0, 1, 1, 1, 1, 0};
        s1_data = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        s1_last = '{0, 0, 0, 0, 1, 0};

        // reset with enable high and data waiting: nothing may leak out
        rst = 1'b1; enable = 1'b1; m_ready = 1'b1; hold_empty = 1'b0;
        en2 = 1'b1; rempty2 = 1'b1; m_ready2 = 1'b1; rdata2 = 8'h5A;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        tick();
        tick();
        @(negedge clk);
        chk("rst_rinc",   32'(rinc),    32'(0));
        chk("rst_valid",  32'(m_valid), 32'(0));
        chk("rst_busy",   32'(busy),    32'(0));
        chk("rst_data",   32'(m_data),  32'(0));
        chk("rst_last",   32'(m_last),  32'(0));

        // first cycle after reset: still IDLE
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("c0_rinc",  32'(rinc),     32'(0));
        chk("c0_valid", 32'(m_valid),  32'(0));
        chk("c0_busy",  32'(busy),     32'(0));
        chk("c0_data",  32'(m_data),   32'(0));
        chk("c0_cnt",   32'(word_cnt), 32'(0));

        // burst of four at full rate
        for (int c = 0; c < 6; c++) begin
            tick();
            @(negedge clk);
            chk($sformatf("s1_rinc[%0d]", c),  32'(rinc),    32'(s1_rinc[c]));
            chk($sformatf("s1_valid[%0d]", c), 32'(m_valid), 32'(s1_vld[c]));
            chk($sformatf("s1_data[%0d]", c),  32'(m_data),  32'(s1_data[c]));
            chk($sformatf("s1_last[%0d]", c),  32'(m_last),  32'(s1_last[c]));
        end
        chk("s1_cnt", 32'(word_cnt), 32'(4));
        chk("s1_busy", 32'(busy), 32'(1));
        chk("s1_n", 32'(out_n), 32'(4));
        chk_out(0, 4, ed, el);

        // backpressure: two pops fill the buffer, head held stable
        tick(); m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("s2_rinc[%0d]", c),  32'(rinc),    32'((c < 2) ? 1 : 0));
            chk($sformatf("s2_valid[%0d]", c), 32'(m_valid), 32'((c > 0) ? 1 : 0));
            chk($sformatf("s2_data[%0d]", c),  32'(m_data),  32'((c > 0) ? 8'hA0 : 8'h00));
            tick();
        end
        m_ready = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        @(negedge clk);
        chk("s2_n", 32'(out_n), 32'(10));
        chk("s2_cnt", 32'(word_cnt), 32'(10));
        chk_out(4, 10, ed, el);

        // enable drops with the buffer full
        tick(); m_ready = 1'b0;
        push(8'hB0); push(8'hB1); push(8'hB2);
        tick();
        tick(); enable = 1'b0;
        @(negedge clk);
        chk("s3_rinc", 32'(rinc), 32'(0));
        tick(); m_ready = 1'b1;
        @(negedge clk);
        chk("s3_state", 32'(u_dut.state), 32'(DRAIN));
        chk("s3_busy",  32'(busy),        32'(1));
        chk("s3_rinc2", 32'(rinc),        32'(0));
        chk("s3_data0", 32'(m_data),      32'(8'hB0));
        tick();
        @(negedge clk);
        chk("s3_data1", 32'(m_data), 32'(8'hB1));
        chk("s3_last",  32'(m_last), 32'(1));
        tick();
        @(negedge clk);
        chk("s3_idle",  32'(u_dut.state), 32'(IDLE));
        chk("s3_busy0", 32'(busy),        32'(0));
        chk("s3_valid", 32'(m_valid),     32'(0));
        chk("s3_cnt",   32'(word_cnt),    32'(12));
        chk_out(10, 12, ed, el);

        // rempty toggling every cycle; B2 is still queued ahead of C0..C8
        tick(); enable = 1'b1;
        for (int i = 0; i < 9; i++) push(8'hC0 + 8'(i));
        for (int c = 0; c < 40; c++) begin
            hold_empty = ~hold_empty;
            tick();
        end
        hold_empty = 1'b0;
        @(negedge clk);
        chk("s4_n", 32'(out_n), 32'(22));
        chk("s4_cnt", 32'(word_cnt), 32'(22));
        chk("s4_underflow", 32'(underflow), 32'(0));
        chk_out(12, 22, ed, el);

        // reset mid-burst: D5 is discarded, D6 restarts framing at beat 0
        tick();
        for (int i = 0; i < 10; i++) push(8'hD0 + 8'(i));
        for (int c = 0; c < 6; c++) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("s5_rst_valid", 32'(m_valid), 32'(0));
        chk("s5_rst_rinc",  32'(rinc),    32'(0));
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("s5_valid", 32'(m_valid),  32'(0));
        chk("s5_busy",  32'(busy),     32'(0));
        chk("s5_cnt0",  32'(word_cnt), 32'(0));
        for (int c = 0; c < 15; c++) tick();
        @(negedge clk);
        chk("s5_n", 32'(out_n), 32'(31));
        chk("s5_cnt", 32'(word_cnt), 32'(4));
        chk_out(22, 31, ed, el);

        // 17 pops into a 4-bit counter, single-beat bursts
        tick(); rempty2 = 1'b0;
        tick();
        @(negedge clk);
        chk("s6_valid", 32'(m_valid2), 32'(1));
        chk("s6_last",  32'(m_last2),  32'(1));
        chk("s6_data",  32'(m_data2),  32'(8'h5A));
        for (int c = 0; c < 16; c++) tick();
        rempty2 = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("s6_pops", 32'(rinc2_n),   32'(17));
        chk("s6_cnt",  32'(word_cnt2), 32'(1));
        chk("s6_underflow", 32'(underflow), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
